// File: rtl/prog_mem_pkg.sv
// Shared constants, FSM state type and line-alignment helper for the program-memory prefetcher.
package prog_mem_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {ISSUE, WAIT, FULL, DRAIN} state_t;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_WORDS - 1);
  endfunction

endpackage

// File: rtl/prog_mem_prefetch_if.sv
// Bundles the cache-control, backing-RAM and cache-fill signals of the prefetcher.
interface prog_mem_prefetch_if;
  import prog_mem_pkg::*;

  logic              line_done;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_we;
  logic              fill_bank;
  logic [IDX_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic [ADDR_W-1:0] fill_base;
  logic              active_bank;
  logic              line_ready;

  modport master (
    input  line_done, redirect, redirect_addr, mem_valid, mem_rdata,
    output mem_req, mem_addr, fill_we, fill_bank, fill_idx, fill_data,
           fill_base, active_bank, line_ready
  );

  modport slave (
    output line_done, redirect, redirect_addr, mem_valid, mem_rdata,
    input  mem_req, mem_addr, fill_we, fill_bank, fill_idx, fill_data,
           fill_base, active_bank, line_ready
  );

endinterface

// File: rtl/prefetch_stats.sv
// Three saturating 16-bit event counters for prefetcher activity.
module prefetch_stats (
  input  logic        clk,
  input  logic        Reset,
  input  logic        line_inc,
  input  logic        redirect_inc,
  input  logic        stall_inc,
  output logic [15:0] stat_lines,
  output logic [15:0] stat_redirects,
  output logic [15:0] stat_stall
);

  always_ff @(posedge clk) begin
    if (Reset) begin
      stat_lines     <= 16'd0;
      stat_redirects <= 16'd0;
      stat_stall     <= 16'd0;
    end else begin
      if (line_inc && stat_lines != 16'hFFFF)
        stat_lines <= stat_lines + 16'd1;
      if (redirect_inc && stat_redirects != 16'hFFFF)
        stat_redirects <= stat_redirects + 16'd1;
      if (stall_inc && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end

endmodule

// File: rtl/prog_mem_prefetch.sv
// Refill engine keeping the shadow cache bank loaded with the next sequential line.
// Optional statistics counters are enabled by defining PREFETCH_STATS_EN.
module prog_mem_prefetch
  import prog_mem_pkg::*;
(
  input logic                 clk,
  input logic                 Reset,
  prog_mem_prefetch_if.master bus
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]         stat_lines,
  output logic [15:0]         stat_redirects,
  output logic [15:0]         stat_stall
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] fill_base_q, fill_base_d;
  logic              fill_bank_q, fill_bank_d;
  logic              active_bank_q, active_bank_d;
  logic              line_ready_q, line_ready_d;
  logic              pend_done_q, pend_done_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fill_we_q, fill_we_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= ISSUE;
      cnt_q         <= '0;
      fill_base_q   <= ADDR_W'(LINE_WORDS);
      fill_bank_q   <= 1'b1;
      active_bank_q <= 1'b0;
      line_ready_q  <= 1'b0;
      pend_done_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      fill_we_q     <= 1'b0;
      fill_idx_q    <= '0;
      fill_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fill_base_q   <= fill_base_d;
      fill_bank_q   <= fill_bank_d;
      active_bank_q <= active_bank_d;
      line_ready_q  <= line_ready_d;
      pend_done_q   <= pend_done_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fill_we_q     <= fill_we_d;
      fill_idx_q    <= fill_idx_d;
      fill_data_q   <= fill_data_d;
    end
  end

  // A redirect while a read is still in flight (WAIT or DRAIN without data this
  // cycle) parks in DRAIN so the stale return can never reach the cache.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_base_d   = fill_base_q;
    fill_bank_d   = fill_bank_q;
    active_bank_d = active_bank_q;
    line_ready_d  = line_ready_q;
    pend_done_d   = pend_done_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    fill_we_d     = 1'b0;
    fill_idx_d    = fill_idx_q;
    fill_data_d   = fill_data_q;

    if (bus.redirect) begin
      fill_bank_d  = active_bank_q;
      fill_base_d  = line_base(bus.redirect_addr);
      cnt_d        = '0;
      line_ready_d = 1'b0;
      pend_done_d  = 1'b0;
      if ((state_q == WAIT || state_q == DRAIN) && !bus.mem_valid)
        state_d = DRAIN;
      else
        state_d = ISSUE;
    end else begin
      if (bus.line_done && state_q != FULL)
        pend_done_d = 1'b1;
      case (state_q)
        ISSUE: begin
          mem_req_d  = 1'b1;
          mem_addr_d = fill_base_q + ADDR_W'(cnt_q);
          state_d    = WAIT;
        end
        WAIT: begin
          if (bus.mem_valid) begin
            fill_we_d   = 1'b1;
            fill_idx_d  = cnt_q;
            fill_data_d = bus.mem_rdata;
            if (cnt_q == LAST_IDX) begin
              cnt_d        = '0;
              line_ready_d = 1'b1;
              state_d      = FULL;
            end else begin
              cnt_d   = cnt_q + IDX_W'(1);
              state_d = ISSUE;
            end
          end
        end
        FULL: begin
          if (bus.line_done || pend_done_q) begin
            active_bank_d = fill_bank_q;
            fill_bank_d   = ~fill_bank_q;
            fill_base_d   = fill_base_q + ADDR_W'(LINE_WORDS);
            line_ready_d  = 1'b0;
            pend_done_d   = 1'b0;
            state_d       = ISSUE;
          end
        end
        DRAIN: begin
          if (bus.mem_valid)
            state_d = ISSUE;
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.fill_we     = fill_we_q;
  assign bus.fill_bank   = fill_bank_q;
  assign bus.fill_idx    = fill_idx_q;
  assign bus.fill_data   = fill_data_q;
  assign bus.fill_base   = fill_base_q;
  assign bus.active_bank = active_bank_q;
  assign bus.line_ready  = line_ready_q;

`ifdef PREFETCH_STATS_EN
  logic line_fill_done;

  assign line_fill_done = (state_q == WAIT) && bus.mem_valid && !bus.redirect &&
                          (cnt_q == LAST_IDX);

  prefetch_stats u_stats (
    .clk            (clk),
    .Reset          (Reset),
    .line_inc       (line_fill_done),
    .redirect_inc   (bus.redirect),
    .stall_inc      (pend_done_q && state_q != FULL),
    .stat_lines     (stat_lines),
    .stat_redirects (stat_redirects),
    .stat_stall     (stat_stall)
  );
`endif

endmodule
